offset_scheduler: RTL and testbench

Clocked controller that sequences character-window movement on the VGA display. It takes four asynchronous direction requests, edge-detects them and queues them as pending moves. Once per frame, at the frame-start pulse, it grants one pending move by round-robin and applies it with bounds checking. Its registered window coordinates feed the pixel-address/character-rendering path; all coordinates are stable for the whole visible frame.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/req_sync_edge.sv | 29 ++
 rtl/offset_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_offset_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA character-window scheduler: display geometry,
// direction indices, scheduler state encoding and the magnify helper.
package vga_pkg;

    localparam logic [10:0] HDT    = 11'd640;
    localparam logic [10:0] VDT    = 11'd400;
    localparam logic [6:0]  HAL    = 7'd8;
    localparam logic [6:0]  VAL    = 7'd16;
    localparam logic [2:0]  MAXMAG = 3'd4;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    localparam logic [9:0] HSTART_RST = 10'((HDT - {4'd0, HAL}) >> 1);
    localparam logic [9:0] VSTART_RST = 10'((VDT - {4'd0, VAL}) >> 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        CLAMP = 3'd2,
        GRANT = 3'd3,
        APPLY = 3'd4
    } schedState;

    // charSize is magnify-minus-one; large codes saturate at MAXMAG
    function automatic logic [2:0] effMag(input logic [2:0] charSize);
        effMag = (charSize >= MAXMAG - 3'd1) ? MAXMAG : charSize + 3'd1;
    endfunction

endpackage

// File: rtl/req_sync_edge.sv
// Two-flop synchroniser for the four asynchronous direction requests,
// followed by a rising-edge detector on the synchronised levels.
module req_sync_edge (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] reqIn,
    output logic [3:0] reqEdge
);

    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] prev;

    // synchroniser chain plus one-cycle history for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
            prev  <= 4'b0000;
        end else begin
            sync1 <= reqIn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign reqEdge = sync2 & ~prev;

endmodule

// File: rtl/offset_scheduler.sv
// Per-frame character-window mover: queues direction requests and applies one
// round-robin grant per frameStart. Define OFFSET_WRAP_EN to wrap at the edges.
module offset_scheduler
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] charSize,
    input  logic [3:0] moveReq,
    input  logic       frameStart,
    output logic [9:0] posHorStart,
    output logic [9:0] posHorEnd,
    output logic [9:0] posVerStart,
    output logic [9:0] posVerEnd,
    output logic       moveDone,
    output logic [3:0] pending
);

    schedState  state;
    logic [2:0] magReg;
    logic [6:0] stepH;
    logic [6:0] stepV;
    logic [1:0] rrPtr;
    logic [1:0] grantDir;

    logic [3:0]  reqEdge;
    logic [10:0] hs, vs, sh, sv;
    logic [9:0]  clampH, clampV, clampHEnd, clampVEnd;
    logic        clampChanged;
    logic [9:0]  applyH, applyV, applyHEnd, applyVEnd;
    logic        grantFound;
    logic [1:0]  grantIdx, idx;
    logic [3:0]  grantMask, pNew, pendingNext;
    logic        hCancel, vCancel;

    req_sync_edge uSync (
        .clk     (clk),
        .reset_n (reset_n),
        .reqIn   (moveReq),
        .reqEdge (reqEdge)
    );

    assign hs = {1'b0, posHorStart};
    assign vs = {1'b0, posVerStart};
    assign sh = {4'd0, stepH};
    assign sv = {4'd0, stepV};

    // pull the window back inside the display after a magnify change
    always_comb begin
        if (hs + sh > HDT) clampH = 10'(HDT - sh);
        else               clampH = posHorStart;
        if (vs + sv > VDT) clampV = 10'(VDT - sv);
        else               clampV = posVerStart;
        clampHEnd    = 10'({1'b0, clampH} + sh);
        clampVEnd    = 10'({1'b0, clampV} + sv);
        clampChanged = (clampH != posHorStart) || (clampV != posVerStart);
    end

    // round-robin search starting at rrPtr
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = rrPtr;
        idx        = rrPtr;
        for (int k = 0; k < 4; k++) begin
            idx        = rrPtr + 2'(k);
            grantIdx   = (!grantFound && pending[idx]) ? idx : grantIdx;
            grantFound = grantFound | pending[idx];
        end
    end

    // queue update: set on edges, clear on grant, then cancel opposing pairs
    always_comb begin
        grantMask   = (state == GRANT && grantFound) ? (4'b0001 << grantIdx) : 4'b0000;
        pNew        = (pending | reqEdge) & ~grantMask;
        hCancel     = pNew[DIR_LEFT] & pNew[DIR_RIGHT];
        vCancel     = pNew[DIR_UP] & pNew[DIR_DOWN];
        pendingNext = pNew & ~{vCancel, vCancel, hCancel, hCancel};
    end

    // bounded (or wrapping) move for the granted direction
    always_comb begin
        applyH = posHorStart;
        applyV = posVerStart;
        case (grantDir)
            DIR_LEFT: begin
                if (hs >= sh) applyH = 10'(hs - sh);
`ifdef OFFSET_WRAP_EN
                else          applyH = 10'(HDT - sh);
`else
                else          applyH = posHorStart;
`endif
            end
            DIR_RIGHT: begin
                if (hs + (sh << 1) <= HDT) applyH = 10'(hs + sh);
`ifdef OFFSET_WRAP_EN
                else                       applyH = 10'd0;
`else
                else                       applyH = posHorStart;
`endif
            end
            DIR_UP: begin
                if (vs >= sv) applyV = 10'(vs - sv);
`ifdef OFFSET_WRAP_EN
                else          applyV = 10'(VDT - sv);
`else
                else          applyV = posVerStart;
`endif
            end
            DIR_DOWN: begin
                if (vs + (sv << 1) <= VDT) applyV = 10'(vs + sv);
`ifdef OFFSET_WRAP_EN
                else                       applyV = 10'd0;
`else
                else                       applyV = posVerStart;
`endif
            end
            default: begin
                applyH = posHorStart;
                applyV = posVerStart;
            end
        endcase
        applyHEnd = 10'({1'b0, applyH} + sh);
        applyVEnd = 10'({1'b0, applyV} + sv);
    end

    // scheduler FSM; coordinates only change between frameStart and the next IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            magReg      <= 3'd1;
            stepH       <= HAL;
            stepV       <= VAL;
            rrPtr       <= 2'd0;
            grantDir    <= 2'd0;
            pending     <= 4'b0000;
            moveDone    <= 1'b0;
            posHorStart <= HSTART_RST;
            posHorEnd   <= 10'(HSTART_RST + {3'd0, HAL});
            posVerStart <= VSTART_RST;
            posVerEnd   <= 10'(VSTART_RST + {3'd0, VAL});
        end else begin
            moveDone <= 1'b0;
            pending  <= pendingNext;
            case (state)
                IDLE: begin
                    if (frameStart) state <= LATCH;
                    else            state <= IDLE;
                end
                LATCH: begin
                    magReg <= effMag(charSize);
                    stepH  <= HAL * {4'd0, effMag(charSize)};
                    stepV  <= VAL * {4'd0, effMag(charSize)};
                    state  <= CLAMP;
                end
                CLAMP: begin
                    posHorStart <= clampH;
                    posHorEnd   <= clampHEnd;
                    posVerStart <= clampV;
                    posVerEnd   <= clampVEnd;
                    moveDone    <= clampChanged;
                    state       <= GRANT;
                end
                GRANT: begin
                    if (grantFound) begin
                        rrPtr    <= grantIdx + 2'd1;
                        grantDir <= grantIdx;
                        state    <= APPLY;
                    end else begin
                        state    <= IDLE;
                    end
                end
                APPLY: begin
                    posHorStart <= applyH;
                    posHorEnd   <= applyHEnd;
                    posVerStart <= applyV;
                    posVerEnd   <= applyVEnd;
                    moveDone    <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_offset_scheduler.sv
// Scoreboard bench for offset_scheduler: stimulus pushes hand-computed window
// states, a monitor pops one on every moveDone pulse and compares.
module tb_offset_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [2:0] charSize = 3'd0;
    logic [3:0] moveReq = 4'b0000;
    logic       frameStart = 1'b0;
    logic [9:0] posHorStart, posHorEnd, posVerStart, posVerEnd;
    logic       moveDone;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] hs;
        logic [9:0] he;
        logic [9:0] vs;
        logic [9:0] ve;
        logic [3:0] pend;
    } expT;

    expT expQ[$];
    expT monE;

    always #5 clk = ~clk;

    offset_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .charSize    (charSize),
        .moveReq     (moveReq),
        .frameStart  (frameStart),
        .posHorStart (posHorStart),
        .posHorEnd   (posHorEnd),
        .posVerStart (posVerStart),
        .posVerEnd   (posVerEnd),
        .moveDone    (moveDone),
        .pending     (pending)
    );

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic pushExp(input int a, input int b, input int c, input int d, input int p);
        expT e;
        e.hs = 10'(a); e.he = 10'(b); e.vs = 10'(c); e.ve = 10'(d); e.pend = 4'(p);
        expQ.push_back(e);
    endtask

    task automatic pulse(input logic [3:0] m);
        @(negedge clk); moveReq = m;
        repeat (2) @(negedge clk);
        moveReq = 4'b0000;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame();
        @(negedge clk); frameStart = 1'b1;
        @(negedge clk); frameStart = 1'b0;
        repeat (10) @(negedge clk);
        checkVal("frame_drain", expQ.size(), 0);
    endtask

    task automatic doReset();
        @(negedge clk); reset_n = 1'b0; moveReq = 4'b0000; frameStart = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // monitor: every moveDone must match the oldest expected window state
    always @(negedge clk) begin
        if (reset_n && moveDone) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_moveDone got h=%0d/%0d v=%0d/%0d p=%b want no pulse",
                         posHorStart, posHorEnd, posVerStart, posVerEnd, pending);
            end else begin
                monE = expQ.pop_front();
                if ({posHorStart, posHorEnd, posVerStart, posVerEnd, pending} !=
                    {monE.hs, monE.he, monE.vs, monE.ve, monE.pend}) begin
                    errors++;
                    $display("FAIL move got h=%0d/%0d v=%0d/%0d p=%b want h=%0d/%0d v=%0d/%0d p=%b",
                             posHorStart, posHorEnd, posVerStart, posVerEnd, pending,
                             monE.hs, monE.he, monE.vs, monE.ve, monE.pend);
                end
            end
        end
    end

    initial begin
        int h;
        int v;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("rst_hs", posHorStart, 316);
        checkVal("rst_he", posHorEnd, 324);
        checkVal("rst_vs", posVerStart, 192);
        checkVal("rst_ve", posVerEnd, 208);
        checkVal("rst_pending", pending, 0);
        checkVal("rst_moveDone", moveDone, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        repeat (3) frame();
        checkVal("idle_hs", posHorStart, 316);
        checkVal("idle_ve", posVerEnd, 208);

        pulse(4'b0010);
        pushExp(324, 332, 192, 208, 0);
        frame();

        // left+up together from rrPtr=0, with 3-cycle request latency
        doReset();
        @(negedge clk); moveReq = 4'b0101;
        repeat (2) @(negedge clk);
        checkVal("lat2_pending", pending, 0);
        @(negedge clk);
        checkVal("lat3_pending", pending, 5);
        moveReq = 4'b0000;
        repeat (4) @(negedge clk);
        pushExp(308, 316, 192, 208, 4);
        frame();
        pushExp(308, 316, 176, 192, 0);
        frame();
        checkVal("lu_pending", pending, 0);

        doReset();
        pulse(4'b0011);
        checkVal("cancel_pending", pending, 0);
        frame();
        checkVal("cancel_hs", posHorStart, 316);

        doReset();
        h = 316;
        for (int i = 0; i < 40; i++) begin
            pulse(4'b0001);
`ifdef OFFSET_WRAP_EN
            h = (h >= 8) ? h - 8 : 632;
`else
            h = (h >= 8) ? h - 8 : h;
`endif
            pushExp(h, h + 8, 192, 208, 0);
            frame();
        end
        checkVal("left_floor_hs", posHorStart, h);

        doReset();
        h = 316;
        for (int i = 0; i < 39; i++) begin
            pulse(4'b0010);
            h = (h + 16 <= 640) ? h + 8 : h;
            pushExp(h, h + 8, 192, 208, 0);
            frame();
        end
        checkVal("pre_clamp_hs", posHorStart, 628);

        charSize = 3'd3;
        pushExp(608, 640, 192, 256, 0);
        frame();

        // charSize 7 must saturate at magnify 4 (stepV 64)
        charSize = 3'd7;
        v = 192;
        for (int i = 0; i < 3; i++) begin
            pulse(4'b1000);
`ifdef OFFSET_WRAP_EN
            v = (v + 128 <= 400) ? v + 64 : 0;
`else
            v = (v + 128 <= 400) ? v + 64 : v;
`endif
            pushExp(608, 640, v, v + 64, 0);
            frame();
        end
        checkVal("final_vs", posVerStart, v);
        checkVal("queue_empty", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
